// File: rtl/jk_excite_seq.sv
`default_nettype none
// ============================================================================
// Module   : jk_excite_seq
// Brief    : Drives J/K of an external JK flip-flop so that Q reaches each
//            offered target bit, then checks Q and counts sent bits and misses.
// Revision : 1.0 - initial release
// ============================================================================
module jk_excite_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             toggle_pref,
    input  logic             clear,
    input  logic             q_in,
    output logic             J,
    output logic             K,
    output logic             mismatch,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_tgt;
    logic             r_j;
    logic             r_k;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_err;

    logic             w_diff;
    logic             w_capture;
    logic             w_j_nxt;
    logic             w_k_nxt;
    logic             w_mis_nxt;
    logic             w_sent_inc;
    logic             w_err_inc;

    assign w_diff = tgt_bit ^ q_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_j_nxt     = 1'b0;
        w_k_nxt     = 1'b0;
        w_mis_nxt   = 1'b0;
        w_sent_inc  = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (tgt_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DRIVE;
                    // Toggle style uses J=K=1 for any change; default style sets/resets
                    if (toggle_pref) begin
                        w_j_nxt = w_diff;
                        w_k_nxt = w_diff;
                    end else begin
                        w_j_nxt = tgt_bit & ~q_in;
                        w_k_nxt = ~tgt_bit & q_in;
                    end
                end
            end
            DRIVE: begin
                w_state_nxt = CHECK;
                w_sent_inc  = 1'b1;
            end
            CHECK: begin
                w_state_nxt = IDLE;
                if (q_in != r_tgt) begin
                    w_mis_nxt = 1'b1;
                    w_err_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tgt      <= 1'b0;
            r_j        <= 1'b0;
            r_k        <= 1'b0;
            r_mismatch <= 1'b0;
            r_sent     <= '0;
            r_err      <= '0;
        end else begin
            r_j        <= w_j_nxt;
            r_k        <= w_k_nxt;
            r_mismatch <= w_mis_nxt;
            if (w_capture) begin
                r_tgt <= tgt_bit;
            end
            // Clear wins over any increment landing on the same edge
            if (clear) begin
                r_sent <= '0;
                r_err  <= '0;
            end else begin
                if (w_sent_inc) begin
                    r_sent <= r_sent + c_cnt_one;
                end
                if (w_err_inc && (r_err != '1)) begin
                    r_err <= r_err + c_cnt_one;
                end
            end
        end
    end

    assign tgt_ready = (r_state == IDLE);
    assign J         = r_j;
    assign K         = r_k;
    assign mismatch  = r_mismatch;
    assign sent_cnt  = r_sent;
    assign err_cnt   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_excite_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_excite_seq
// Brief    : Directed self-checking bench for jk_excite_seq with a JK flip-flop
//            model in the feedback loop and a narrow-counter second instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_excite_seq;

    logic       clk         = 1'b0;
    logic       reset       = 1'b0;
    logic       tgt_valid   = 1'b0;
    logic       tgt_bit     = 1'b0;
    logic       toggle_pref = 1'b0;
    logic       clear       = 1'b0;
    logic       q_ff        = 1'b0;
    logic       q_stuck     = 1'b0;
    logic       q_zero      = 1'b0;
    logic       q_in;

    logic       tgt_ready, J, K, mismatch;
    logic [7:0] sent_cnt, err_cnt;
    logic       tgt_ready2, J2, K2, mismatch2;
    logic [1:0] sent_cnt2, err_cnt2;

    int n_pass  = 0;
    int n_total = 0;

    assign q_in = q_stuck ? 1'b0 : q_ff;

    jk_excite_seq #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .toggle_pref(toggle_pref), .clear(clear),
        .q_in(q_in), .J(J), .K(K), .mismatch(mismatch),
        .sent_cnt(sent_cnt), .err_cnt(err_cnt)
    );

    jk_excite_seq #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready2), .toggle_pref(toggle_pref), .clear(clear),
        .q_in(q_zero), .J(J2), .K(K2), .mismatch(mismatch2),
        .sent_cnt(sent_cnt2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    // External JK flip-flop driven by the DUT
    always @(posedge clk) begin
        case ({J, K})
            2'b10:   q_ff <= 1'b1;
            2'b01:   q_ff <= 1'b0;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge following the compare edge
    task automatic xfer(input logic tgt, input logic tp, output logic [1:0] jk,
                        output logic [1:0] jk2, output logic mis, output logic mis2);
        int n = 0;
        while (tgt_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_hs", 32'(tgt_ready), 32'd1);
        tgt_valid   = 1'b1;
        tgt_bit     = tgt;
        toggle_pref = tp;
        @(negedge clk);
        jk  = {J, K};
        jk2 = {J2, K2};
        check("ready_in_drive", 32'(tgt_ready), 32'd0);
        tgt_valid   = 1'b0;
        tgt_bit     = ~tgt;
        toggle_pref = ~tp;
        @(negedge clk);
        check("jk_in_check", 32'({J, K}), 32'd0);
        check("ready_in_check", 32'(tgt_ready), 32'd0);
        check("mis_before_cmp", 32'(mismatch), 32'd0);
        @(negedge clk);
        mis  = mismatch;
        mis2 = mismatch2;
        check("ready_after_cmp", 32'(tgt_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] jk, jk2;
        logic       mis, mis2;
        logic       nb;
        logic       bp_mis;
        logic [1:0] exp_jk_a [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
        logic       tgt_a    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       tgt_b    [3] = '{1'b1, 1'b0, 1'b1};

        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #2;
        check("rst_j", 32'(J), 32'd0);
        check("rst_k", 32'(K), 32'd0);
        check("rst_mis", 32'(mismatch), 32'd0);
        check("rst_sent", 32'(sent_cnt), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_ready", 32'(tgt_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Default style through the real flip-flop, starting at Q=0
        for (int i = 0; i < 4; i++) begin
            xfer(tgt_a[i], 1'b0, jk, jk2, mis, mis2);
            check("dflt_jk", 32'(jk), 32'(exp_jk_a[i]));
            check("dflt_mis", 32'(mis), 32'd0);
            check("dflt_q", 32'(q_ff), 32'(tgt_a[i]));
        end
        check("dflt_sent", 32'(sent_cnt), 32'd4);
        check("dflt_err", 32'(err_cnt), 32'd0);

        // Toggle style
        for (int i = 0; i < 3; i++) begin
            xfer(tgt_b[i], 1'b1, jk, jk2, mis, mis2);
            check("tgl_jk", 32'(jk), 32'd3);
            check("tgl_mis", 32'(mis), 32'd0);
            check("tgl_q", 32'(q_ff), 32'(tgt_b[i]));
        end
        check("tgl_sent", 32'(sent_cnt), 32'd7);
        check("tgl_err", 32'(err_cnt), 32'd0);

        // Feedback stuck at 0 with target 1
        q_stuck = 1'b1;
        xfer(1'b1, 1'b0, jk, jk2, mis, mis2);
        check("fault_jk", 32'(jk), 32'd2);
        check("fault_mis_e2", 32'(mis), 32'd1);
        check("fault_err", 32'(err_cnt), 32'd1);
        check("fault_sent", 32'(sent_cnt), 32'd8);
        @(negedge clk);
        check("fault_mis_e3", 32'(mismatch), 32'd0);
        q_stuck = 1'b0;

        // Back-pressure: valid held high, data scrambled while not ready
        nb          = 1'b1;
        bp_mis      = 1'b0;
        tgt_valid   = 1'b1;
        toggle_pref = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("bp_ready", 32'(tgt_ready), 32'((i % 3) == 0));
            bp_mis = bp_mis | mismatch;
            if (tgt_ready) begin
                tgt_bit = nb;
                nb      = ~nb;
            end else begin
                tgt_bit     = nb;
                toggle_pref = ~toggle_pref;
            end
            if ((i % 3) == 0) toggle_pref = 1'b0;
            @(negedge clk);
        end
        tgt_valid   = 1'b0;
        toggle_pref = 1'b0;
        bp_mis      = bp_mis | mismatch;
        check("bp_mis", 32'(bp_mis), 32'd0);
        check("bp_sent", 32'(sent_cnt), 32'd12);
        check("bp_err", 32'(err_cnt), 32'd1);
        check("bp_q", 32'(q_ff), 32'd0);

        // Reset asserted mid-DRIVE
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        check("mid_jk_drive", 32'({J, K}), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_jk", 32'({J, K}), 32'd0);
        check("mid_rst_ready", 32'(tgt_ready), 32'd1);
        check("mid_rst_sent", 32'(sent_cnt), 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        check("mid_rst_mis", 32'(mismatch), 32'd0);
        reset = 1'b0;
        xfer(1'b1, 1'b0, jk, jk2, mis, mis2);
        check("post_rst_jk", 32'(jk), 32'd2);
        check("post_rst_mis", 32'(mis), 32'd0);
        check("post_rst_sent", 32'(sent_cnt), 32'd1);

        // Narrow counters: saturation and wrap
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("nar_sent0", 32'(sent_cnt2), 32'd0);
        check("nar_err0", 32'(err_cnt2), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            xfer(1'b1, 1'b0, jk, jk2, mis, mis2);
            check("nar_jk", 32'(jk2), 32'd2);
            check("nar_mis", 32'(mis2), 32'd1);
            check("nar_sent", 32'(sent_cnt2), 32'(k % 4));
            check("nar_err", 32'(err_cnt2), 32'((k < 3) ? k : 3));
        end
        check("wide_sent5", 32'(sent_cnt), 32'd5);

        // Clear on the compare edge: counters zeroed, pulse still emitted
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        check("clr_pre_sent", 32'(sent_cnt2), 32'd2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_mis", 32'(mismatch2), 32'd1);
        check("clr_sent2", 32'(sent_cnt2), 32'd0);
        check("clr_err2", 32'(err_cnt2), 32'd0);
        check("clr_sent", 32'(sent_cnt), 32'd0);
        @(negedge clk);
        check("clr_mis_end", 32'(mismatch2), 32'd0);
        check("clr_err_hold", 32'(err_cnt2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
